// File: rtl/bus_arbiter_drv.sv
// bus_arbiter_drv: two-source arbiter feeding the 4-bit tristate bus buffer.
// Grants the shared bus to source A or B and registers the driven word and the
// buffer enable. A one-cycle bus-free TURN gap is inserted between owners.
// Under contention, ownership is bounded to MAX_BURST consecutive cycles.
//
// Handshake: req_a/req_b are level requests. They are sampled on every rising
// edge and are never latched. A source owns the bus, and sees its data on
// drv_data, in every cycle where its gnt is high. gnt_x rises at the first edge
// at which the arbiter grants req_x. It falls at the edge where req_x is seen
// low, or where the burst limit is reached while the other source requests.
module bus_arbiter_drv #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             drv_en,
    output logic [WIDTH-1:0] drv_data,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        TURN  = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  burst_cnt, cnt_nxt;
    logic           last_owner, last_nxt;   // 0 = A, 1 = B
    logic           gnt_a_nxt, gnt_b_nxt, drv_en_nxt;
    logic [WIDTH-1:0] drv_data_nxt;

    // State, burst counter, fairness memory and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            drv_en     <= 1'b0;
            drv_data   <= '0;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= cnt_nxt;
            last_owner <= last_nxt;
            gnt_a      <= gnt_a_nxt;
            gnt_b      <= gnt_b_nxt;
            drv_en     <= drv_en_nxt;
            drv_data   <= drv_data_nxt;
        end
    end

    // Next-state: arbitrate from IDLE/TURN, bound or release ownership otherwise.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = burst_cnt;
        last_nxt  = last_owner;
        case (state)
            IDLE, TURN: begin
                // On contention the source that did not own last wins.
                if (req_a && (!req_b || last_owner)) begin
                    state_nxt = OWN_A;
                    cnt_nxt   = '0;
                    last_nxt  = 1'b0;
                end else if (req_b) begin
                    state_nxt = OWN_B;
                    cnt_nxt   = '0;
                    last_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            OWN_A: begin
                if (!req_a || (req_b && burst_cnt == CNT_MAX)) begin
                    state_nxt = TURN;
                end else if (burst_cnt != CNT_MAX) begin
                    cnt_nxt = burst_cnt + 1'b1;
                end
            end
            OWN_B: begin
                if (!req_b || (req_a && burst_cnt == CNT_MAX)) begin
                    state_nxt = TURN;
                end else if (burst_cnt != CNT_MAX) begin
                    cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: bus drive values taken from the next state, busy from the current state.
    always_comb begin
        gnt_a_nxt    = (state_nxt == OWN_A);
        gnt_b_nxt    = (state_nxt == OWN_B);
        drv_en_nxt   = gnt_a_nxt | gnt_b_nxt;
        drv_data_nxt = '0;
        if (gnt_a_nxt)      drv_data_nxt = data_a;
        else if (gnt_b_nxt) drv_data_nxt = data_b;
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_bus_arbiter_drv.sv
// Testbench for bus_arbiter_drv: directed scenarios plus random traffic,
// checked edge by edge against an ownership-level reference model.
module tb_bus_arbiter_drv;

    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;
    localparam int OW        = WIDTH + 4;   // {gnt_a, gnt_b, drv_en, busy, drv_data}

    logic             clk;
    logic             rst_n;
    logic             req_a, req_b;
    logic [WIDTH-1:0] data_a, data_b;
    logic             gnt_a, gnt_b, drv_en, busy;
    logic [WIDTH-1:0] drv_data;

    int checks = 0;
    int errors = 0;

    logic [OW-1:0] exp_q[$];

    // Reference model state, in terms of ownership rather than RTL state.
    int m_owner;     // 0 none, 1 A, 2 B
    bit m_gap;       // last edge ended an ownership
    int m_run;       // cycles the current owner has held the bus
    int m_last;      // 1 A, 2 B

    bus_arbiter_drv #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a),
        .req_b(req_b), .data_b(data_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .drv_en(drv_en), .drv_data(drv_data), .busy(busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = 0;
        m_gap   = 0;
        m_run   = 0;
        m_last  = 2;
    endtask

    // Apply one rising edge with the given inputs to the model; return expected outputs.
    task automatic model_edge(input bit ra, input logic [WIDTH-1:0] da,
                              input bit rb, input logic [WIDTH-1:0] db,
                              output logic [OW-1:0] exp_v);
        bit self_req, other_req;
        logic [WIDTH-1:0] d;
        if (m_owner == 0) begin
            int pick;
            pick = 0;
            if (ra && rb)  pick = (m_last == 1) ? 2 : 1;
            else if (ra)   pick = 1;
            else if (rb)   pick = 2;
            m_gap = 0;
            if (pick != 0) begin
                m_owner = pick;
                m_run   = 1;
                m_last  = pick;
            end
        end else begin
            self_req  = (m_owner == 1) ? ra : rb;
            other_req = (m_owner == 1) ? rb : ra;
            if (!self_req || (other_req && m_run >= MAX_BURST)) begin
                m_owner = 0;
                m_gap   = 1;
            end else begin
                m_run++;
            end
        end
        d = (m_owner == 1) ? da : (m_owner == 2) ? db : '0;
        exp_v = {m_owner == 1, m_owner == 2, m_owner != 0, (m_owner != 0) || m_gap, d};
    endtask

    // Driver: called at a negedge; sets inputs for the next edge, queues the expectation.
    task automatic drive(input bit ra, input logic [WIDTH-1:0] da,
                         input bit rb, input logic [WIDTH-1:0] db);
        logic [OW-1:0] e;
        req_a  = ra;
        data_a = da;
        req_b  = rb;
        data_b = db;
        model_edge(ra, da, rb, db, e);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        logic [OW-1:0] act;
        act = {gnt_a, gnt_b, drv_en, busy, drv_data};
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, {OW{1'b0}});
        end
    endtask

    // Scoreboard monitor: after each edge, compare DUT outputs with the oldest expectation.
    initial begin
        logic [OW-1:0] act, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {gnt_a, gnt_b, drv_en, busy, drv_data};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL edge @%0t: got {ga,gb,en,busy,data}=%b expected %b",
                             $time, act, e);
                end
                checks++;
                if (gnt_a && gnt_b) begin
                    errors++;
                    $display("FAIL exclusive @%0t: got gnt_a=1 gnt_b=1 expected at most one",
                             $time);
                end
            end
        end
    end

    // Stimulus
    initial begin
        model_reset();
        rst_n  = 1'b0;
        req_a  = 1'b1;
        data_a = 4'b1010;
        req_b  = 1'b0;
        data_b = 4'b0000;
        #1;
        check_zero("reset_immediate");
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset release with A requesting, then single owner and release.
        drive(1, 4'b1010, 0, 4'b0000);
        repeat (3) drive(1, 4'b0101, 0, 4'b0000);
        drive(0, 4'b0101, 0, 4'b0000);   // TURN
        drive(0, 4'b0101, 0, 4'b0000);   // IDLE
        drive(0, 4'b0000, 0, 4'b0000);

        // Contention: A then B then A, bounded by MAX_BURST with TURN gaps.
        repeat (16) drive(1, 4'b0011, 1, 4'b1111);
        drive(0, 4'b0000, 0, 4'b0000);
        drive(0, 4'b0000, 0, 4'b0000);

        // Uncontended long burst of B, then A joins after saturation.
        repeat (10) drive(0, 4'b0000, 1, 4'b0110);
        repeat (2) drive(1, 4'b1001, 1, 4'b0110);
        repeat (3) drive(0, 4'b0000, 0, 4'b0000);

        // Data tracking while A owns.
        drive(1, 4'b0001, 0, 4'b1111);
        drive(1, 4'b0010, 0, 4'b1111);
        drive(1, 4'b0100, 0, 4'b1111);
        drive(1, 4'b1000, 0, 4'b1111);
        drive(0, 4'b0000, 0, 4'b0000);
        drive(0, 4'b0000, 0, 4'b0000);

        // Request dropped before a grant is never granted; MAX_BURST boundary on B.
        drive(1, 4'b0111, 1, 4'b1100);
        repeat (5) drive(0, 4'b0000, 1, 4'b1100);
        drive(1, 4'b0111, 0, 4'b1100);
        repeat (3) drive(0, 4'b0000, 0, 4'b0000);

        // Async reset while B owns: outputs drop between edges.
        repeat (3) drive(0, 4'b0000, 1, 4'b1101);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_mid_own");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (6) drive(1, 4'b0110, 1, 4'b1001);

        // Random traffic with sticky requests so bursts and contention both occur.
        for (int i = 0; i < 600; i++) begin
            bit ra, rb;
            ra = ($urandom_range(0, 9) < 7) ? req_a : ~req_a;
            rb = ($urandom_range(0, 9) < 7) ? req_b : ~req_b;
            drive(ra, WIDTH'($urandom_range(0, 15)), rb, WIDTH'($urandom_range(0, 15)));
        end
        drive(0, 4'b0000, 0, 4'b0000);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
